wb_regfile_2w: RTL and testbench
================================

// Module: wb_regfile_2w
// PURPOSE
//  Write-back consumer for the two MEM/WB pipeline lanes of the 2-way core.
//  Per lane, selects the result (load data, ALU result or JAL link), and commits it to a
//  32x32 register file with 2 write ports.
//  Serves 4 combinational read ports (rs/rt per lane) to the decode stage, with write-through bypass.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  DATA_W       32  register/data width
//  LINK_OFFSET  8   byte offset added to WB_PC for the JAL link value (delay-slot MIPS)
//  CNT_W        32  retired-instruction counter width
// PORTS
//  clk               in   1       core clock, all state updates on rising edge
//  Reset_n           in   1       asynchronous, active-low reset
//  WB_valid0/1       in   1       lane holds a real instruction this cycle (lane1 = younger)
//  RegWrite_WB0/1    in   1       lane writes a destination register
//  MemtoReg_WB0/1    in   1       1: write readData, 0: write aluResult
//  JAL_WB0/1         in   1       write link value (overrides MemtoReg)
//  WriteReg_WB0/1    in   5       destination register index
//  readData_WB0/1    in   DATA_W  load data from MEM/WB
//  aluResult_WB0/1   in   DATA_W  ALU result from MEM/WB
//  WB_PC0/1          in   32      PC of the lane's instruction
//  rd_addr0..3       in   5       read addresses (0/1: lane0 rs/rt, 2/3: lane1 rs/rt)
//  rd_data0..3       out  DATA_W  read data, combinational
//  wb_data0/1        out  DATA_W  selected write-back value per lane (for forwarding units)
//  retired_cnt       out  CNT_W   count of retired valid instructions
// BEHAVIOUR
//  - Reset (Reset_n=0, async): all 32 registers=0, retired_cnt=0; held while asserted.
//    Any write presented in the cycle reset asserts is lost.
//  - Lane write enable: we_n = WB_valid_n & RegWrite_WB_n & (WriteReg_WB_n != 0).
//  - Data select per lane: JAL ? WB_PC+LINK_OFFSET (mod 2^32) : MemtoReg ? readData : aluResult.
//    wb_data_n reflects this regardless of enable.
//  - Commit: at the rising clk edge, enabled lanes write the register file. Write latency is 1 edge.
//  - Both lanes write the same register: lane1 value is stored (program order); lane0 is discarded.
//  - $0: never written; reads of address 0 always return 0 (also through bypass).
//  - Reads: 0-cycle combinational.
//    Priority: lane1 bypass (we1 & addr==WriteReg_WB1), then lane0 bypass, then array.
//    A read therefore sees the value that will be committed at the next edge.
//  - retired_cnt: +0/+1/+2 per edge = WB_valid0 + WB_valid1, independent of RegWrite.
//    Wraps modulo 2^CNT_W; there is no saturation.
//  - No stall/handshake: lanes are consumed every cycle; invalid lanes have no side effect.
//  - Reset released mid-stream: first edge after release commits normally.
// STRUCTURE
//  - Shared package (core_pkg): REG_ZERO=5'd0, REG_RA=5'd31, NUM_REGS=32.
//    Also holds the DATA_W default and the LINK_OFFSET default.
//  - Sub-module wb_lane_mux: purely combinational per-lane data select plus enable generation.
//    Instantiated twice.
//  - Top module: register array, two write ports, four bypassed read muxes, retired counter.
// TESTING
//  1. Reset_n=0 mid-run after writing 0xDEADBEEF to $5, then release.
//     Expected: rd_data for $5 = 0, retired_cnt = 0.
//  2. Lane0: MemtoReg=1, readData=0x11111111 to $8. Lane1: ALU 0x22222222 to $9, both valid.
//     Expected: next cycle $8=0x11111111, $9=0x22222222, retired_cnt += 2.
//  3. Both lanes write $10: lane0 0xAAAA0000, lane1 0x0000BBBB.
//     Expected: same-cycle read of $10 = 0x0000BBBB; after the edge, array $10 = 0x0000BBBB.
//  4. Lane1 JAL, WB_PC1=0x00400010, WriteReg=31.
//     Expected: wb_data1 = 0x00400018; after the edge, $31 = 0x00400018.
//  5. Write 0x12345678 to $0 with valid=1; also valid=0 with RegWrite=1 to $7.
//     Expected: $0 reads 0; $7 unchanged; retired_cnt +1.
//  6. Preload retired_cnt=2^CNT_W-1, then issue both lanes valid.
//     Expected: retired_cnt = 1 (wrap).

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants for the write-back / register file slice.
// Register indices and width defaults used across stages.
package core_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int LINK_OFFSET_DEF = 8;
  localparam int CNT_W_DEF       = 32;
  localparam int NUM_REGS        = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_2w_if.sv
// MEM/WB lane bundle plus decode read ports of the
// dual-write register file.
interface wb_regfile_2w_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              WB_valid0;
    logic              WB_valid1;
    logic              RegWrite_WB0;
    logic              RegWrite_WB1;
    logic              MemtoReg_WB0;
    logic              MemtoReg_WB1;
    logic              JAL_WB0;
    logic              JAL_WB1;
    logic [4:0]        WriteReg_WB0;
    logic [4:0]        WriteReg_WB1;
    logic [DATA_W-1:0] readData_WB0;
    logic [DATA_W-1:0] readData_WB1;
    logic [DATA_W-1:0] aluResult_WB0;
    logic [DATA_W-1:0] aluResult_WB1;
    logic [31:0]       WB_PC0;
    logic [31:0]       WB_PC1;
    logic [4:0]        rd_addr0;
    logic [4:0]        rd_addr1;
    logic [4:0]        rd_addr2;
    logic [4:0]        rd_addr3;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] rd_data3;
    logic [DATA_W-1:0] wb_data0;
    logic [DATA_W-1:0] wb_data1;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output WB_valid0, WB_valid1,
        output RegWrite_WB0, RegWrite_WB1,
        output MemtoReg_WB0, MemtoReg_WB1,
        output JAL_WB0, JAL_WB1,
        output WriteReg_WB0, WriteReg_WB1,
        output readData_WB0, readData_WB1,
        output aluResult_WB0, aluResult_WB1,
        output WB_PC0, WB_PC1,
        output rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        input  rd_data0, rd_data1, rd_data2, rd_data3,
        input  wb_data0, wb_data1,
        input  retired_cnt
    );

    modport slave (
        input  WB_valid0, WB_valid1,
        input  RegWrite_WB0, RegWrite_WB1,
        input  MemtoReg_WB0, MemtoReg_WB1,
        input  JAL_WB0, JAL_WB1,
        input  WriteReg_WB0, WriteReg_WB1,
        input  readData_WB0, readData_WB1,
        input  aluResult_WB0, aluResult_WB1,
        input  WB_PC0, WB_PC1,
        input  rd_addr0, rd_addr1, rd_addr2, rd_addr3,
        output rd_data0, rd_data1, rd_data2, rd_data3,
        output wb_data0, wb_data1,
        output retired_cnt
    );
endinterface

// File: rtl/wb_lane_mux.sv
// Per-lane write-back select: link / load / ALU value,
// plus the register-file write enable for that lane.
module wb_lane_mux
    import core_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LINK_OFFSET = LINK_OFFSET_DEF
) (
    input  logic              valid,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              jal,
    input  reg_idx_t          wreg,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] alu,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] wb_data,
    output logic              we
);
    logic [31:0] link;

    assign link = pc + 32'(LINK_OFFSET);

    always_comb begin
        wb_data = alu;
        if (jal) begin
            wb_data = DATA_W'(link);
        end else if (mem_to_reg) begin
            wb_data = rdata;
        end
    end

    assign we = valid & reg_write & (wreg != REG_ZERO);
endmodule

// File: rtl/wb_regfile_2w.sv
// Dual-lane write-back register file: 2 write ports,
// 4 bypassed combinational read ports, retired counter.
module wb_regfile_2w
    import core_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LINK_OFFSET = LINK_OFFSET_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            Reset_n,
    wb_regfile_2w_if.slave  bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] wb0;
    logic [DATA_W-1:0] wb1;
    logic              we0;
    logic              we1;
    reg_idx_t          ra [4];
    logic [DATA_W-1:0] rd [4];

    wb_lane_mux #(.DATA_W(DATA_W), .LINK_OFFSET(LINK_OFFSET)) u_lane0 (
        .valid      (bus.WB_valid0),
        .reg_write  (bus.RegWrite_WB0),
        .mem_to_reg (bus.MemtoReg_WB0),
        .jal        (bus.JAL_WB0),
        .wreg       (bus.WriteReg_WB0),
        .rdata      (bus.readData_WB0),
        .alu        (bus.aluResult_WB0),
        .pc         (bus.WB_PC0),
        .wb_data    (wb0),
        .we         (we0)
    );

    wb_lane_mux #(.DATA_W(DATA_W), .LINK_OFFSET(LINK_OFFSET)) u_lane1 (
        .valid      (bus.WB_valid1),
        .reg_write  (bus.RegWrite_WB1),
        .mem_to_reg (bus.MemtoReg_WB1),
        .jal        (bus.JAL_WB1),
        .wreg       (bus.WriteReg_WB1),
        .rdata      (bus.readData_WB1),
        .alu        (bus.aluResult_WB1),
        .pc         (bus.WB_PC1),
        .wb_data    (wb1),
        .we         (we1)
    );

    // lane1 is younger, so its write lands last on a collision
    always_comb begin
        regs_d = regs_q;
        if (we0) regs_d[bus.WriteReg_WB0] = wb0;
        if (we1) regs_d[bus.WriteReg_WB1] = wb1;
        regs_d[REG_ZERO] = '0;
        cnt_d = cnt_q + CNT_W'(bus.WB_valid0)
                      + CNT_W'(bus.WB_valid1);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ra[0] = bus.rd_addr0;
    assign ra[1] = bus.rd_addr1;
    assign ra[2] = bus.rd_addr2;
    assign ra[3] = bus.rd_addr3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd[i] = regs_q[ra[i]];
            if (we0 && ra[i] == bus.WriteReg_WB0) rd[i] = wb0;
            if (we1 && ra[i] == bus.WriteReg_WB1) rd[i] = wb1;
            if (ra[i] == REG_ZERO) rd[i] = '0;
        end
    end

    assign bus.rd_data0    = rd[0];
    assign bus.rd_data1    = rd[1];
    assign bus.rd_data2    = rd[2];
    assign bus.rd_data3    = rd[3];
    assign bus.wb_data0    = wb0;
    assign bus.wb_data1    = wb1;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_wb_regfile_2w.sv
// Scoreboard bench for wb_regfile_2w with a small
// counter width so wrap-around is reachable.
module tb_wb_regfile_2w;
    localparam int CW = 4;

    typedef struct {
        bit          valid;
        bit          rw;
        bit          mtr;
        bit          jal;
        logic [4:0]  wr;
        logic [31:0] rdat;
        logic [31:0] alu;
        logic [31:0] pc;
    } lane_t;

    typedef struct {
        logic [4:0]    a [4];
        logic [31:0]   rd [4];
        logic [31:0]   wb0;
        logic [31:0]   wb1;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 0;
    logic Reset_n = 0;
    always #5 clk = ~clk;

    wb_regfile_2w_if #(.DATA_W(32), .CNT_W(CW)) bus ();

    wb_regfile_2w #(.DATA_W(32), .LINK_OFFSET(8), .CNT_W(CW)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    logic [31:0] mdl [32];
    int unsigned mcnt;
    exp_t        sbq [$];
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] sel(lane_t l);
        if (l.jal) return l.pc + 32'd8;
        if (l.mtr) return l.rdat;
        return l.alu;
    endfunction

    function automatic bit en(lane_t l);
        return l.valid && l.rw && l.wr != 5'd0;
    endfunction

    function automatic lane_t idle();
        lane_t l;
        l = '{default: 0};
        return l;
    endfunction

    function automatic lane_t mk(bit v, bit rw, bit m, bit j,
                                 logic [4:0] wr, logic [31:0] d,
                                 logic [31:0] a, logic [31:0] pc);
        lane_t l;
        l.valid = v; l.rw = rw; l.mtr = m; l.jal = j;
        l.wr = wr; l.rdat = d; l.alu = a; l.pc = pc;
        return l;
    endfunction

    task automatic apply(lane_t l0, lane_t l1,
                         logic [4:0] a0, logic [4:0] a1,
                         logic [4:0] a2, logic [4:0] a3);
        bus.WB_valid0 = l0.valid;     bus.WB_valid1 = l1.valid;
        bus.RegWrite_WB0 = l0.rw;     bus.RegWrite_WB1 = l1.rw;
        bus.MemtoReg_WB0 = l0.mtr;    bus.MemtoReg_WB1 = l1.mtr;
        bus.JAL_WB0 = l0.jal;         bus.JAL_WB1 = l1.jal;
        bus.WriteReg_WB0 = l0.wr;     bus.WriteReg_WB1 = l1.wr;
        bus.readData_WB0 = l0.rdat;   bus.readData_WB1 = l1.rdat;
        bus.aluResult_WB0 = l0.alu;   bus.aluResult_WB1 = l1.alu;
        bus.WB_PC0 = l0.pc;           bus.WB_PC1 = l1.pc;
        bus.rd_addr0 = a0; bus.rd_addr1 = a1;
        bus.rd_addr2 = a2; bus.rd_addr3 = a3;
    endtask

    // one cycle: drive, predict visible outputs, then advance model
    task automatic drive(lane_t l0, lane_t l1,
                         logic [4:0] a0, logic [4:0] a1,
                         logic [4:0] a2, logic [4:0] a3, bit chk);
        logic [31:0] nxt [32];
        exp_t e;
        @(posedge clk);
        #1;
        apply(l0, l1, a0, a1, a2, a3);
        nxt = mdl;
        if (en(l0)) nxt[l0.wr] = sel(l0);
        if (en(l1)) nxt[l1.wr] = sel(l1);
        e.a[0] = a0; e.a[1] = a1; e.a[2] = a2; e.a[3] = a3;
        for (int i = 0; i < 4; i++)
            e.rd[i] = (e.a[i] == 5'd0) ? 32'd0 : nxt[e.a[i]];
        e.wb0 = sel(l0);
        e.wb1 = sel(l1);
        e.cnt = CW'(mcnt);
        if (chk) sbq.push_back(e);
        if (Reset_n) begin
            mdl = nxt;
            mcnt = (mcnt + 32'(l0.valid) + 32'(l1.valid)) % (1 << CW);
        end
    endtask

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] act [4];
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                act[0] = bus.rd_data0; act[1] = bus.rd_data1;
                act[2] = bus.rd_data2; act[3] = bus.rd_data3;
                for (int i = 0; i < 4; i++)
                    cmp($sformatf("rd_data%0d[$%0d]", i, e.a[i]),
                        act[i], e.rd[i]);
                cmp("wb_data0", bus.wb_data0, e.wb0);
                cmp("wb_data1", bus.wb_data1, e.wb1);
                cmp("retired_cnt", 32'(bus.retired_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        apply(mk(1, 1, 0, 0, 5'd6, 0, 32'hCAFE0006, 0), idle(),
              0, 0, 0, 0);
        Reset_n = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        mcnt = 0;
        drive(idle(), idle(), 5'd5, 5'd6, 5'd0, 5'd31, 1);
        @(posedge clk);
        #1;
        Reset_n = 1;
    endtask

    initial begin : stim
        lane_t l0, l1;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        mcnt = 0;
        apply(idle(), idle(), 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1;
        drive(idle(), idle(), 5'd1, 5'd5, 5'd31, 5'd0, 1);

        // write $5 then reset mid-run; $5 must read back 0
        drive(mk(1, 1, 0, 0, 5'd5, 0, 32'hDEADBEEF, 0), idle(),
              5'd5, 5'd0, 5'd0, 5'd0, 1);
        drive(idle(), idle(), 5'd5, 5'd0, 5'd0, 5'd0, 1);
        do_reset();
        drive(idle(), idle(), 5'd5, 5'd6, 5'd5, 5'd6, 1);

        // load on lane0, ALU on lane1
        drive(mk(1, 1, 1, 0, 5'd8, 32'h11111111, 32'h99, 0),
              mk(1, 1, 0, 0, 5'd9, 32'h77, 32'h22222222, 0),
              5'd8, 5'd9, 5'd8, 5'd9, 1);
        drive(idle(), idle(), 5'd8, 5'd9, 5'd0, 5'd0, 1);

        // both lanes hit $10; lane1 wins
        drive(mk(1, 1, 0, 0, 5'd10, 0, 32'hAAAA0000, 0),
              mk(1, 1, 0, 0, 5'd10, 0, 32'h0000BBBB, 0),
              5'd10, 5'd10, 5'd10, 5'd10, 1);
        drive(idle(), idle(), 5'd10, 5'd8, 5'd9, 5'd10, 1);

        // JAL link on lane1
        drive(idle(), mk(1, 1, 1, 1, 5'd31, 32'h5, 32'h6, 32'h00400010),
              5'd31, 5'd0, 5'd31, 5'd0, 1);
        drive(idle(), idle(), 5'd31, 5'd0, 5'd0, 5'd0, 1);

        // $0 write and invalid lane write
        drive(mk(1, 1, 0, 0, 5'd0, 0, 32'h12345678, 0),
              mk(0, 1, 0, 0, 5'd7, 0, 32'h77777777, 0),
              5'd0, 5'd7, 5'd0, 5'd7, 1);
        drive(idle(), idle(), 5'd0, 5'd7, 5'd0, 5'd7, 1);

        // counter to 2^CW-1, then both lanes valid -> wraps to 1
        do_reset();
        for (int i = 0; i < 7; i++)
            drive(mk(1, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0),
                  0, 0, 0, 0, 1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0), idle(), 0, 0, 0, 0, 1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0),
              0, 0, 0, 0, 1);
        drive(idle(), idle(), 0, 0, 0, 0, 1);

        // random traffic, small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            l0 = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                    5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            l1 = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                    5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) l1.wr = 5'($urandom_range(0, 31));
            drive(l0, l1,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), 1);
        end
        drive(idle(), idle(), 5'd1, 5'd2, 5'd3, 5'd4, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0",
                     sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
